// File: rtl/video_binarizer_wb_pkg.sv
// Shared constants for the video binarizer: Wishbone register map and core identification.
package video_binarizer_wb_pkg;

  localparam int unsigned ADR_CORE_ID     = 'h00;
  localparam int unsigned ADR_CTL_CONTROL = 'h04;
  localparam int unsigned ADR_CTL_STATUS  = 'h05;
  localparam int unsigned ADR_PARAM_TH    = 'h08;
  localparam int unsigned ADR_PARAM_INV   = 'h09;

  localparam logic [31:0] CORE_ID = 32'h527a_2110;

endpackage

// File: rtl/video_binarizer_core.sv
// Two-stage stream pipeline: stage0 captures the beat plus its parameter snapshot,
// stage1 produces the thresholded binary pixel next to the unchanged gray pixel.
module video_binarizer_core #(
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDATA_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic [TUSER_WIDTH-1:0] s_tuser_i,
  input  logic                   s_tlast_i,
  input  logic [TDATA_WIDTH-1:0] s_tdata_i,
  input  logic                   s_tvalid_i,
  output logic                   s_tready_o,

  input  logic [TDATA_WIDTH-1:0] param_th_i,
  input  logic                   param_inv_i,

  output logic [TUSER_WIDTH-1:0] m_tuser_o,
  output logic                   m_tlast_o,
  output logic [TDATA_WIDTH-1:0] m_tdata_o,
  output logic                   m_tbinary_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i
);

  logic                   cke;
  logic                   s0_valid_q;
  logic [TUSER_WIDTH-1:0] s0_user_q;
  logic                   s0_last_q;
  logic [TDATA_WIDTH-1:0] s0_data_q;
  logic [TDATA_WIDTH-1:0] s0_th_q;
  logic                   s0_inv_q;

  logic                   s1_valid_q;
  logic [TUSER_WIDTH-1:0] s1_user_q;
  logic                   s1_last_q;
  logic [TDATA_WIDTH-1:0] s1_data_q;
  logic                   s1_binary_q;

  // The whole pipeline freezes together whenever the output is stalled.
  assign cke        = ~s1_valid_q | m_tready_i;
  assign s_tready_o = cke;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q  <= 1'b0;
      s0_user_q   <= '0;
      s0_last_q   <= 1'b0;
      s0_data_q   <= '0;
      s0_th_q     <= '0;
      s0_inv_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_user_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_binary_q <= 1'b0;
    end else if (cke) begin
      s0_valid_q  <= s_tvalid_i;
      s0_user_q   <= s_tuser_i;
      s0_last_q   <= s_tlast_i;
      s0_data_q   <= s_tdata_i;
      s0_th_q     <= param_th_i;
      s0_inv_q    <= param_inv_i;
      s1_valid_q  <= s0_valid_q;
      s1_user_q   <= s0_user_q;
      s1_last_q   <= s0_last_q;
      s1_data_q   <= s0_data_q;
      s1_binary_q <= (s0_data_q > s0_th_q) ^ s0_inv_q;
    end
  end

  assign m_tuser_o   = s1_user_q;
  assign m_tlast_o   = s1_last_q;
  assign m_tdata_o   = s1_data_q;
  assign m_tbinary_o = s1_binary_q;
  assign m_tvalid_o  = s1_valid_q;

endmodule

// File: rtl/video_binarizer_wb.sv
// Gray-to-binary video stage with a Wishbone register file; new threshold/invert
// settings are latched into the datapath only on a frame-start beat.
module video_binarizer_wb
  import video_binarizer_wb_pkg::*;
#(
  parameter int unsigned             TUSER_WIDTH    = 1,
  parameter int unsigned             TDATA_WIDTH    = 8,
  parameter int unsigned             WB_ADR_WIDTH   = 8,
  parameter int unsigned             WB_DAT_WIDTH   = 32,
  parameter int unsigned             WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter logic [TDATA_WIDTH-1:0]  INIT_PARAM_TH  = TDATA_WIDTH'(127),
  parameter logic                    INIT_PARAM_INV = 1'b0
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]  s_axi4s_tdata,
  input  logic                    s_axi4s_tvalid,
  output logic                    s_axi4s_tready,

  output logic [TUSER_WIDTH-1:0]  m_axi4s_tuser,
  output logic                    m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]  m_axi4s_tdata,
  output logic                    m_axi4s_tbinary,
  output logic                    m_axi4s_tvalid,
  input  logic                    m_axi4s_tready,

  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o
);

  logic [TDATA_WIDTH-1:0] reg_th_q, reg_th_d;
  logic                   reg_inv_q;
  logic [TDATA_WIDTH-1:0] shadow_th_q;
  logic                   shadow_inv_q;
  logic                   pending_q;
  logic                   synced_q;

  logic                   wb_wr;
  logic                   wr_ctl, wr_th, wr_inv;
  logic                   in_accept, frame_start, apply;
  logic                   core_valid;
  logic [TDATA_WIDTH-1:0] core_th;
  logic                   core_inv;

  assign wb_wr  = s_wb_stb_i & s_wb_we_i;
  assign wr_ctl = wb_wr & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_CONTROL)) & s_wb_sel_i[0]
                  & s_wb_dat_i[0];
  assign wr_th  = wb_wr & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH));
  assign wr_inv = wb_wr & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_INV)) & s_wb_sel_i[0];

  assign in_accept   = s_axi4s_tvalid & s_axi4s_tready;
  assign frame_start = in_accept & s_axi4s_tuser[0];
  assign apply       = frame_start & pending_q;

  // The applying beat itself must already see the new settings.
  assign core_th  = apply ? reg_th_q  : shadow_th_q;
  assign core_inv = apply ? reg_inv_q : shadow_inv_q;

  // Until the first frame start after reset, partial-frame beats are consumed and dropped.
  assign core_valid = s_axi4s_tvalid & (s_axi4s_tuser[0] | synced_q);

  always_comb begin
    reg_th_d = reg_th_q;
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      if (wr_th && s_wb_sel_i[i / 8]) begin
        reg_th_d[i] = s_wb_dat_i[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reg_th_q     <= INIT_PARAM_TH;
      reg_inv_q    <= INIT_PARAM_INV;
      shadow_th_q  <= INIT_PARAM_TH;
      shadow_inv_q <= INIT_PARAM_INV;
      pending_q    <= 1'b0;
      synced_q     <= 1'b0;
    end else begin
      reg_th_q  <= reg_th_d;
      if (wr_inv) begin
        reg_inv_q <= s_wb_dat_i[0];
      end
      // Shadow copies the pre-write register; a same-cycle request re-arms pending.
      if (apply) begin
        shadow_th_q  <= reg_th_q;
        shadow_inv_q <= reg_inv_q;
      end
      pending_q <= wr_ctl | (pending_q & ~apply);
      synced_q  <= synced_q | frame_start;
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      WB_ADR_WIDTH'(ADR_CORE_ID):     s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      WB_ADR_WIDTH'(ADR_CTL_CONTROL): s_wb_dat_o[0] = pending_q;
      WB_ADR_WIDTH'(ADR_CTL_STATUS):  s_wb_dat_o[0] = pending_q;
      WB_ADR_WIDTH'(ADR_PARAM_TH):    s_wb_dat_o[TDATA_WIDTH-1:0] = reg_th_q;
      WB_ADR_WIDTH'(ADR_PARAM_INV):   s_wb_dat_o[0] = reg_inv_q;
      default:                        s_wb_dat_o = '0;
    endcase
  end

  assign s_wb_ack_o = s_wb_stb_i;

  video_binarizer_core #(
    .TUSER_WIDTH (TUSER_WIDTH),
    .TDATA_WIDTH (TDATA_WIDTH)
  ) u_core (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .s_tuser_i   (s_axi4s_tuser),
    .s_tlast_i   (s_axi4s_tlast),
    .s_tdata_i   (s_axi4s_tdata),
    .s_tvalid_i  (core_valid),
    .s_tready_o  (s_axi4s_tready),
    .param_th_i  (core_th),
    .param_inv_i (core_inv),
    .m_tuser_o   (m_axi4s_tuser),
    .m_tlast_o   (m_axi4s_tlast),
    .m_tdata_o   (m_axi4s_tdata),
    .m_tbinary_o (m_axi4s_tbinary),
    .m_tvalid_o  (m_axi4s_tvalid),
    .m_tready_i  (m_axi4s_tready)
  );

endmodule

// File: tb/tb_video_binarizer_wb.sv
// Directed bench for video_binarizer_wb: stream beats are scored against a small
// reference model of the shadowed threshold/invert settings.
module tb_video_binarizer_wb;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic [7:0]  m_tdata;
  logic        m_tbinary;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [7:0]  wb_adr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic        wb_stb = 1'b0;
  logic        wb_ack;

  always #5 aclk = ~aclk;

  video_binarizer_wb dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axi4s_tuser   (s_tuser),
    .s_axi4s_tlast   (s_tlast),
    .s_axi4s_tdata   (s_tdata),
    .s_axi4s_tvalid  (s_tvalid),
    .s_axi4s_tready  (s_tready),
    .m_axi4s_tuser   (m_tuser),
    .m_axi4s_tlast   (m_tlast),
    .m_axi4s_tdata   (m_tdata),
    .m_axi4s_tbinary (m_tbinary),
    .m_axi4s_tvalid  (m_tvalid),
    .m_axi4s_tready  (m_tready),
    .s_wb_adr_i      (wb_adr),
    .s_wb_dat_i      (wb_dat_i),
    .s_wb_dat_o      (wb_dat_o),
    .s_wb_we_i       (wb_we),
    .s_wb_sel_i      (wb_sel),
    .s_wb_stb_i      (wb_stb),
    .s_wb_ack_o      (wb_ack)
  );

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
    logic       bin;
  } beat_t;

  int tests = 0;
  int fails = 0;

  beat_t       exp_q[$];
  logic [7:0]  md_reg_th = 8'd127, md_sh_th = 8'd127;
  logic        md_reg_inv = 1'b0, md_sh_inv = 1'b0, md_pend = 1'b0, md_sync = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       held;
  logic        obs_valid, obs_ack;
  logic [31:0] obs_dat;

  logic        nx_stb = 1'b0, nx_we = 1'b0;
  logic [7:0]  nx_adr = '0;
  logic [31:0] nx_dat = '0;
  logic [3:0]  nx_sel = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic golden(input logic [7:0] d, input logic [7:0] th, input logic inv);
    return (d > th) ^ inv;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    md_reg_th = 8'd127; md_sh_th = 8'd127;
    md_reg_inv = 1'b0; md_sh_inv = 1'b0;
    md_pend = 1'b0; md_sync = 1'b0; prev_stall = 1'b0;
  endtask

  // One clock: drive at negedge, score outputs and update the model, then wait for posedge.
  task automatic cyc(input logic v, input logic u, input logic l, input logic [7:0] d,
                     input logic rdy);
    beat_t cur, e;
    @(negedge aclk);
    s_tvalid = v; s_tuser = u; s_tlast = l; s_tdata = d; m_tready = rdy;
    wb_stb = nx_stb; wb_we = nx_we; wb_adr = nx_adr; wb_dat_i = nx_dat; wb_sel = nx_sel;
    #1;
    obs_valid = m_tvalid; obs_ack = wb_ack; obs_dat = wb_dat_o;
    cur = '{user: m_tuser[0], last: m_tlast, data: m_tdata, bin: m_tbinary};
    if (prev_stall) begin
      check("stall_valid", 32'(m_tvalid), 32'd1);
      check("stall_hold", 32'(cur), 32'(held));
    end
    if (m_tvalid && m_tready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 32'(cur), 32'(e));
      end
    end
    prev_stall = m_tvalid & ~m_tready;
    held = cur;
    if (v && s_tready) begin
      if (u && md_pend) begin
        md_sh_th = md_reg_th; md_sh_inv = md_reg_inv; md_pend = 1'b0;
      end
      if (u) md_sync = 1'b1;
      if (md_sync) exp_q.push_back('{user: u, last: l, data: d, bin: golden(d, md_sh_th, md_sh_inv)});
    end
    if (nx_stb && nx_we && nx_sel[0]) begin
      if (nx_adr == 8'h04 && nx_dat[0]) md_pend = 1'b1;
      if (nx_adr == 8'h08) md_reg_th = nx_dat[7:0];
      if (nx_adr == 8'h09) md_reg_inv = nx_dat[0];
    end
    nx_stb = 1'b0; nx_we = 1'b0;
    @(posedge aclk);
  endtask

  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    nx_stb = 1'b1; nx_we = 1'b1; nx_adr = adr; nx_dat = dat; nx_sel = sel;
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic wb_rd(input logic [7:0] adr);
    nx_stb = 1'b1; nx_we = 1'b0; nx_adr = adr; nx_dat = '0; nx_sel = 4'hF;
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic drain(input string tag);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", {m_tuser, m_tlast, m_tbinary, m_tdata}, 32'd0);
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;

    // 1: latency, then a full 0..255 ramp with default 127/0
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("lat_cycle1", 32'(obs_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("lat_cycle2", 32'(obs_valid), 32'd1);
    for (int i = 1; i < 256; i++) cyc(1'b1, 1'b0, (i == 255), 8'(i), 1'b1);
    drain("ramp_drained");

    // 2: mid-frame reprogramming, applied only at the next frame start
    cyc(1'b1, 1'b1, 1'b0, 8'd126, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'd127, 1'b1);
    wb_wr(8'h08, 32'd200, 4'hF);
    wb_wr(8'h09, 32'd1, 4'hF);
    wb_wr(8'h04, 32'd1, 4'hF);
    wb_rd(8'h05);
    check("status_pending", obs_dat, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'd128, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd201, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'd199, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'd200, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'd201, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd0, 1'b1);
    wb_rd(8'h05);
    check("status_applied", obs_dat, 32'd0);
    wb_rd(8'h08);
    check("th_200", obs_dat, 32'd200);
    drain("frame2_drained");

    // 3: random valid/ready with a reprogram in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000) begin nx_stb = 1; nx_we = 1; nx_adr = 8'h08; nx_dat = 32'd90; nx_sel = 4'hF; end
      if (i == 1001) begin nx_stb = 1; nx_we = 1; nx_adr = 8'h04; nx_dat = 32'd1; nx_sel = 4'hF; end
      cyc(1'($urandom_range(0, 1)), (i % 50 == 0), (i % 50 == 49), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
    end
    drain("random_drained");
    wb_wr(8'h08, 32'd200, 4'hF);

    // 4: TH write colliding with an applying frame start; CTL write colliding with apply
    wb_wr(8'h04, 32'd1, 4'hF);
    nx_stb = 1; nx_we = 1; nx_adr = 8'h08; nx_dat = 32'd50; nx_sel = 4'hF;
    cyc(1'b1, 1'b1, 1'b0, 8'd60, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'd100, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd201, 1'b1);
    wb_rd(8'h05);
    check("status_collide", obs_dat, 32'd0);
    wb_wr(8'h04, 32'd1, 4'hF);
    nx_stb = 1; nx_we = 1; nx_adr = 8'h04; nx_dat = 32'd1; nx_sel = 4'hF;
    cyc(1'b1, 1'b1, 1'b0, 8'd40, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd51, 1'b1);
    wb_rd(8'h05);
    check("status_rearmed", obs_dat, 32'd1);
    wb_wr(8'h09, 32'd0, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 8'd50, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd51, 1'b1);
    drain("frame4_drained");

    // 5: reset mid-frame with a stalled output
    cyc(1'b1, 1'b1, 1'b0, 8'd10, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd11, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    wb_rd(8'h00);
    check("core_id", obs_dat, 32'h527a_2110);
    check("core_id_ack", 32'(obs_ack), 32'd1);
    wb_rd(8'h08);
    check("th_reset", obs_dat, 32'd127);
    wb_rd(8'h09);
    check("inv_reset", obs_dat, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'd200, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd201, 1'b1);
    drain("partial_dropped");
    cyc(1'b1, 1'b1, 1'b0, 8'd127, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'd128, 1'b1);
    drain("restart_drained");

    // 6: byte selects and unmapped address
    wb_wr(8'h08, 32'h0000_FFFF & 32'h0000_FF05, 4'b0010);
    wb_rd(8'h08);
    check("th_sel_masked", obs_dat, 32'd127);
    wb_wr(8'h0F, 32'hFFFF_FFFF, 4'hF);
    wb_rd(8'h0F);
    check("unmapped_read", obs_dat, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
